// File: rtl/muldiv_ctrl_pkg.sv
// muldiv_ctrl_pkg: op and FSM state encodings shared by the multiply/divide unit and the pipeline controller
package muldiv_ctrl_pkg;

    typedef enum logic [2:0] {
        OP_MULT  = 3'b000,
        OP_MULTU = 3'b001,
        OP_DIV   = 3'b010,
        OP_DIVU  = 3'b011,
        OP_MTHI  = 3'b100,
        OP_MTLO  = 3'b101
    } op_e;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MUL  = 2'd1,
        S_DIV  = 2'd2
    } state_e;

endpackage

// File: rtl/muldiv_ctrl_if.sv
// muldiv_ctrl_if: E-stage request and HI/LO result bundle between pipeline (master) and multiply/divide unit (slave)
interface muldiv_ctrl_if;

    logic        start;
    logic [2:0]  op;
    logic [31:0] D1;
    logic [31:0] D2;
    logic        md_use_D;
    logic        busy;
    logic        stall_md;
    logic [31:0] hi;
    logic [31:0] lo;

    modport master (
        output start, op, D1, D2, md_use_D,
        input  busy, stall_md, hi, lo
    );

    modport slave (
        input  start, op, D1, D2, md_use_D,
        output busy, stall_md, hi, lo
    );

endinterface

// File: rtl/muldiv_ctrl.sv
// muldiv_ctrl: fixed-latency multiply/divide unit; results sit in pending registers until the countdown commits them to HI/LO
module muldiv_ctrl
    import muldiv_ctrl_pkg::*;
#(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic           clk,
    input  logic           reset_n,
    muldiv_ctrl_if.slave   bus
);

    state_e      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        busy_q, busy_d;
    logic [31:0] hi_q, hi_d;
    logic [31:0] lo_q, lo_d;
    logic [31:0] pend_hi_q, pend_hi_d;
    logic [31:0] pend_lo_q, pend_lo_d;

    logic [63:0] prod_s, prod_u;
    logic [31:0] quo_s, rem_s, quo_u, rem_u;
    logic        div_zero;

    // Low 64 bits of the sign-extended product equal the signed 32x32 product
    assign prod_s   = {{32{bus.D1[31]}}, bus.D1} * {{32{bus.D2[31]}}, bus.D2};
    assign prod_u   = {32'd0, bus.D1} * {32'd0, bus.D2};
    assign quo_s    = $signed(bus.D1) / $signed(bus.D2);
    assign rem_s    = $signed(bus.D1) % $signed(bus.D2);
    assign quo_u    = bus.D1 / bus.D2;
    assign rem_u    = bus.D1 % bus.D2;
    assign div_zero = bus.D2 == 32'd0;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        pend_hi_d = pend_hi_q;
        pend_lo_d = pend_lo_q;
        case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    case (bus.op)
                        OP_MULT, OP_MULTU: begin
                            pend_hi_d = bus.op == OP_MULT ? prod_s[63:32] : prod_u[63:32];
                            pend_lo_d = bus.op == OP_MULT ? prod_s[31:0]  : prod_u[31:0];
                            cnt_d     = 4'(MULT_CYCLES - 1);
                            state_d   = S_MUL;
                        end
                        OP_DIV, OP_DIVU: begin
                            // Divide by zero recommits the current HI/LO so the full latency still elapses
                            pend_hi_d = div_zero ? hi_q : bus.op == OP_DIV ? rem_s : rem_u;
                            pend_lo_d = div_zero ? lo_q : bus.op == OP_DIV ? quo_s : quo_u;
                            cnt_d     = 4'(DIV_CYCLES - 1);
                            state_d   = S_DIV;
                        end
                        OP_MTHI: hi_d = bus.D1;
                        OP_MTLO: lo_d = bus.D1;
                        default: ;
                    endcase
                end
            end
            S_MUL, S_DIV: begin
                if (cnt_q == 4'd0) begin
                    hi_d    = pend_hi_q;
                    lo_d    = pend_lo_q;
                    state_d = S_IDLE;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            default: state_d = S_IDLE;
        endcase
        busy_d = state_d != S_IDLE;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= S_IDLE;
            cnt_q     <= 4'd0;
            busy_q    <= 1'b0;
            hi_q      <= 32'd0;
            lo_q      <= 32'd0;
            pend_hi_q <= 32'd0;
            pend_lo_q <= 32'd0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            busy_q    <= busy_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            pend_hi_q <= pend_hi_d;
            pend_lo_q <= pend_lo_d;
        end
    end

    assign bus.busy     = busy_q;
    assign bus.stall_md = (bus.start | busy_q) & bus.md_use_D;
    assign bus.hi       = hi_q;
    assign bus.lo       = lo_q;

endmodule

// File: tb/tb_muldiv_ctrl.sv
// tb_muldiv_ctrl: directed vectors with hand-computed HI/LO results and busy latencies
module tb_muldiv_ctrl;
    import muldiv_ctrl_pkg::*;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    int   n_cmp = 0;
    int   n_bad = 0;
    int   n_busy;

    muldiv_ctrl_if bus ();

    muldiv_ctrl #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    // Launch one op, then count busy cycles; HI/LO must hold their old value while busy
    task automatic run_op(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                          input bit inject, output int n);
        logic [31:0] hi0, lo0;
        @(posedge clk); #1;
        hi0 = bus.hi;
        lo0 = bus.lo;
        bus.start = 1'b1; bus.op = o; bus.D1 = a; bus.D2 = b;
        @(posedge clk); #1;
        bus.start = 1'b0;
        n = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (!bus.busy) break;
            n++;
            chk("hi_hold", bus.hi, hi0);
            chk("lo_hold", bus.lo, lo0);
            if (bus.md_use_D) chk("stall_busy", 32'(bus.stall_md), 32'd1);
            if (inject && n == 2) begin
                bus.start = 1'b1; bus.op = OP_MTHI; bus.D1 = 32'hdead;
            end else begin
                bus.start = 1'b0;
            end
        end
        bus.start = 1'b0;
    endtask

    task automatic mt(input logic [2:0] o, input logic [31:0] a);
        @(posedge clk); #1;
        bus.start = 1'b1; bus.op = o; bus.D1 = a;
        @(posedge clk); #1;
        bus.start = 1'b0;
        chk("mt_busy", 32'(bus.busy), 32'd0);
    endtask

    initial begin
        bus.start = 1'b0; bus.op = 3'd0; bus.D1 = '0; bus.D2 = '0; bus.md_use_D = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_busy", 32'(bus.busy), 32'd0);
        chk("rst_hi", bus.hi, 32'd0);
        chk("rst_lo", bus.lo, 32'd0);
        chk("rst_stall", 32'(bus.stall_md), 32'd0);
        @(negedge clk) reset_n = 1'b1;

        run_op(OP_MULT, 32'hFFFFFFFF, 32'd2, 1'b0, n_busy);
        chk("mult_cycles", n_busy, 32'd5);
        chk("mult_hi", bus.hi, 32'hFFFFFFFF);
        chk("mult_lo", bus.lo, 32'hFFFFFFFE);

        run_op(OP_MULTU, 32'hFFFFFFFF, 32'd2, 1'b0, n_busy);
        chk("multu_cycles", n_busy, 32'd5);
        chk("multu_hi", bus.hi, 32'h00000001);
        chk("multu_lo", bus.lo, 32'hFFFFFFFE);

        run_op(OP_DIV, -32'sd7, 32'd2, 1'b0, n_busy);
        chk("div_cycles", n_busy, 32'd10);
        chk("div_lo", bus.lo, 32'hFFFFFFFD);
        chk("div_hi", bus.hi, 32'hFFFFFFFF);

        run_op(OP_DIV, 32'd7, -32'sd2, 1'b0, n_busy);
        chk("div_neg_lo", bus.lo, 32'hFFFFFFFD);
        chk("div_neg_hi", bus.hi, 32'd1);

        run_op(OP_DIVU, 32'd100, 32'd7, 1'b0, n_busy);
        chk("divu_lo", bus.lo, 32'd14);
        chk("divu_hi", bus.hi, 32'd2);

        mt(OP_MTHI, 32'h11);
        chk("mthi_hi", bus.hi, 32'h11);
        mt(OP_MTLO, 32'h22);
        chk("mtlo_lo", bus.lo, 32'h22);
        chk("mtlo_hi_kept", bus.hi, 32'h11);

        run_op(OP_DIVU, 32'h1234, 32'd0, 1'b0, n_busy);
        chk("div0_cycles", n_busy, 32'd10);
        chk("div0_hi", bus.hi, 32'h11);
        chk("div0_lo", bus.lo, 32'h22);

        mt(3'b110, 32'h99);
        chk("undef_hi", bus.hi, 32'h11);
        chk("undef_lo", bus.lo, 32'h22);

        bus.md_use_D = 1'b1;
        run_op(OP_MULT, 32'd3, 32'd4, 1'b1, n_busy);
        chk("inj_cycles", n_busy, 32'd5);
        chk("inj_hi", bus.hi, 32'd0);
        chk("inj_lo", bus.lo, 32'd12);
        chk("stall_after", 32'(bus.stall_md), 32'd0);
        bus.md_use_D = 1'b0;

        mt(OP_MTHI, 32'h77);
        @(posedge clk); #1;
        bus.start = 1'b1; bus.op = OP_DIV; bus.D1 = -32'sd7; bus.D2 = 32'd2;
        @(posedge clk); #1;
        bus.start = 1'b0;
        repeat (3) @(negedge clk);
        reset_n = 1'b0;
        #1;
        chk("abort_busy", 32'(bus.busy), 32'd0);
        chk("abort_hi", bus.hi, 32'd0);
        chk("abort_lo", bus.lo, 32'd0);
        @(negedge clk);
        reset_n = 1'b1;
        bus.start = 1'b1; bus.op = OP_MTHI; bus.D1 = 32'd5;
        @(posedge clk); #1;
        bus.start = 1'b0;
        chk("post_rst_mthi", bus.hi, 32'd5);
        repeat (12) @(negedge clk);
        chk("no_late_commit_lo", bus.lo, 32'd0);
        chk("no_late_busy", 32'(bus.busy), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/muldiv_ctrl.md
MULDIV_CTRL -- requirements
Module: muldiv_ctrl

Interface
REQ-001 The block SHALL declare parameter MULT_CYCLES, default 5, the multiply latency in cycles from start to result.
REQ-002 The block SHALL declare parameter DIV_CYCLES, default 10, the divide latency in cycles from start to result.
REQ-003 The block SHALL have one clock and an asynchronous active-low reset: clk input 1, rising-edge clock; reset_n input 1, async active-low reset.
REQ-004 Port start: input, 1 bit; E-stage pulse launching op.
REQ-005 Port op: input, 3 bits; 000 mult, 001 multu, 010 div, 011 divu, 100 mthi, 101 mtlo, others no-op.
REQ-006 Port D1: input, 32 bits; rs operand.
REQ-007 Port D2: input, 32 bits; rt operand.
REQ-008 Port md_use_D: input, 1 bit; D-stage instruction is mult/div/mfhi/mflo/mthi/mtlo.
REQ-009 Port busy: output, 1 bit; operation in flight.
REQ-010 Port stall_md: output, 1 bit; pipeline stall request.
REQ-011 Port hi: output, 32 bits; architectural HI.
REQ-012 Port lo: output, 32 bits; architectural LO.

Function
REQ-013 State machine SHALL have states IDLE, MUL, DIV; cnt SHALL be a 4-bit down-counter.
REQ-014 In IDLE, start with op mult/multu SHALL capture the 64-bit product into pending registers, load cnt with MULT_CYCLES-1, and enter MUL.
REQ-015 In IDLE, start with op div/divu SHALL capture quotient and remainder into pending registers, load cnt with DIV_CYCLES-1, and enter DIV.
REQ-016 mult SHALL use signed arithmetic and multu unsigned; product[63:32] SHALL go to HI and product[31:0] to LO.
REQ-017 div SHALL be signed with quotient truncated toward zero and remainder taking the sign of the dividend; divu SHALL be unsigned; quotient SHALL go to LO and remainder to HI.
REQ-018 Divide with D2==0 SHALL run the full DIV_CYCLES latency and leave hi and lo unchanged.
REQ-019 In MUL/DIV, cnt SHALL decrement each cycle; when cnt==0, pending SHALL commit to hi/lo on that edge and the state SHALL return to IDLE.
REQ-020 busy SHALL be registered, high from the cycle after start through the commit cycle inclusive, i.e. MULT_CYCLES or DIV_CYCLES cycles; hi/lo SHALL show the new value in the first cycle busy is low.
REQ-021 mthi/mtlo in IDLE SHALL write D1 to hi/lo at the next edge with no busy assertion.
REQ-022 start while busy SHALL be ignored entirely, with no state, counter or HI/LO change.
REQ-023 stall_md SHALL be combinational and equal (start | busy) & md_use_D.
REQ-024 start with an undefined op SHALL be a no-op.
REQ-025 hi and lo SHALL be driven only from architectural registers; pending values SHALL never be visible on hi or lo.

Reset
REQ-026 When reset_n is low, the block SHALL asynchronously force state IDLE, cnt 0, busy 0, hi 0, lo 0, and pending 0.
REQ-027 Reset mid-operation SHALL abort without commit; after release, the block SHALL accept start on the first rising edge.

Structure
REQ-028 Op encodings and state encodings SHALL live in the shared MIPS definitions header and be used by both this block and the controller.
REQ-029 The block SHALL use no sub-module; arithmetic, FSM and counter SHALL be inline.
REQ-030 Parameters SHALL satisfy 1 <= MULT_CYCLES and DIV_CYCLES <= 16.

Verification
REQ-031 Scenario mult: D1=0xFFFFFFFF, D2=2, op=mult -> busy high for 5 cycles; then hi=0xFFFFFFFF, lo=0xFFFFFFFE.
REQ-032 Scenario multu: same operands with op=multu -> hi=0x00000001, lo=0xFFFFFFFE.
REQ-033 Scenario div: D1=-7, D2=2, op=div -> busy for 10 cycles; then lo=0xFFFFFFFD (-3), hi=0xFFFFFFFF (-1).
REQ-034 Scenario divide by zero: hi=0x11, lo=0x22, then divu with D2=0 -> busy for 10 cycles; hi=0x11 and lo=0x22 unchanged.
REQ-035 Scenario stall and ignored start: md_use_D=1 during busy -> stall_md=1 every busy cycle and 0 after; a second start during busy changes neither timing nor result.
REQ-036 Scenario reset mid-operation: reset_n low at cycle 3 of a div -> busy, hi, lo go 0 immediately; a following mthi with D1=5 gives hi=5 at the next edge.
